// File: rtl/app_mult_serial_acc16_pkg.sv
// Shared types and default sizes for the serial approximate-multiplier accumulator.
// APP_MULT_LAYER_REG_EN adds one cycle of layer-result latency.
package app_mult_serial_acc16_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int WIDTH_DEF  = 16;
    localparam int DIGITS_DEF = WIDTH_DEF / 2;
    localparam int LSUM_W_DEF = WIDTH_DEF + 2;
    localparam int PROD_W_DEF = 2 * WIDTH_DEF;
    localparam int ACC_GUARD  = 3;

`ifdef APP_MULT_LAYER_REG_EN
    localparam int LAYER_LAT = 1;
`else
    localparam int LAYER_LAT = 0;
`endif

endpackage

// File: rtl/app_mult_serial_acc16_ctrl.sv
// FSM, digit counter and handshake strobes for the serial multiplier accumulator.
// APP_MULT_LAYER_REG_EN delays each capture by one cycle relative to its drive.
module serial_acc_ctrl
    import app_mult_serial_acc16_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int KW     = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    input  logic          out_ready_i,
    output logic          in_ready_o,
    output logic [KW-1:0] k_o,
    output logic [KW-1:0] acc_k_o,
    output logic          acc_clr_o,
    output logic          acc_en_o,
    output logic          done_o
);

    localparam logic [KW-1:0] LAST_K = KW'(DIGITS - 1 + LAYER_LAT);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // With the layer register, the digit being captured trails the driven digit by one.
`ifdef APP_MULT_LAYER_REG_EN
    assign acc_k_o = k_q - KW'(1);
`else
    assign acc_k_o = k_q;
`endif

    assign k_o = k_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        in_ready_o = 1'b0;
        acc_clr_o  = 1'b0;
        acc_en_o   = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    acc_clr_o = 1'b1;
                    k_d       = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
`ifdef APP_MULT_LAYER_REG_EN
                acc_en_o = (k_q != '0);
`else
                acc_en_o = 1'b1;
`endif
                k_d = k_q + KW'(1);
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

endmodule

// File: rtl/app_mult_serial_acc16.sv
// Serial signed 16x16 multiplier controller: drives a 16x2 partial-product layer per B digit
// and shift-accumulates its sum. APP_MULT_LAYER_REG_EN registers lay_sum before accumulation.
module app_mult_serial_acc16
    import app_mult_serial_acc16_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = WIDTH / 2,
    parameter int LSUM_W = WIDTH + 2,
    parameter int PROD_W = 2 * WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic [WIDTH-1:0]  lay_a,
    output logic              lay_b_low,
    output logic              lay_b_high,
    output logic              lay_cin,
    input  logic [LSUM_W-1:0] lay_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod
);

    localparam int KW    = $clog2(DIGITS + 1);
    localparam int IW    = $clog2(WIDTH);
    localparam int ACC_W = PROD_W + ACC_GUARD;

    logic [WIDTH-1:0]  a_q, b_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  sum_ext;
    logic [LSUM_W-1:0] sum_src;
    logic [KW-1:0]     k, acc_k, dig_idx;
    logic [IW-1:0]     bit_lo, bit_hi;
    logic              acc_clr, acc_en, done;

    serial_acc_ctrl #(
        .DIGITS (DIGITS),
        .KW     (KW)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .k_o         (k),
        .acc_k_o     (acc_k),
        .acc_clr_o   (acc_clr),
        .acc_en_o    (acc_en),
        .done_o      (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (acc_clr) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

    // The drain cycle of the registered-layer build lets k reach DIGITS; clamp the mux index.
    assign dig_idx = (k < KW'(DIGITS)) ? k : KW'(DIGITS - 1);
    assign bit_lo  = IW'({dig_idx, 1'b0});
    assign bit_hi  = IW'({dig_idx, 1'b1});

    assign lay_a      = a_q;
    assign lay_b_low  = b_q[bit_lo];
    assign lay_b_high = b_q[bit_hi];
    assign lay_cin    = 1'b0;

`ifdef APP_MULT_LAYER_REG_EN
    logic [LSUM_W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= lay_sum;
        end
    end

    assign sum_src = sum_q;
`else
    assign sum_src = lay_sum;
`endif

    assign sum_ext = {{(ACC_W - LSUM_W){sum_src[LSUM_W-1]}}, sum_src};

    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + (sum_ext << {acc_k, 1'b0});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Guard bits are dropped without saturation.
    assign out_valid = done;
    assign out_prod  = done ? acc_q[PROD_W-1:0] : '0;

endmodule

// File: tb/tb_app_mult_serial_acc16.sv
// Self-checking bench for app_mult_serial_acc16 with a behavioural partial-product layer.
// Honours APP_MULT_LAYER_REG_EN for the expected latency.
module tb_app_mult_serial_acc16;

    localparam int DIGITS = 8;
`ifdef APP_MULT_LAYER_REG_EN
    localparam int LAT = DIGITS + 1;
`else
    localparam int LAT = DIGITS;
`endif
    localparam int SPACING = LAT + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [15:0] lay_a;
    logic        lay_b_low, lay_b_high, lay_cin;
    logic [17:0] lay_sum;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_prod;

    int nChecks = 0;
    int nPass   = 0;
    int tbDig;
    int digVal;
    int layA;

    always #5 clk = ~clk;

    app_mult_serial_acc16 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .lay_a      (lay_a),
        .lay_b_low  (lay_b_low),
        .lay_b_high (lay_b_high),
        .lay_cin    (lay_cin),
        .lay_sum    (lay_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prod   (out_prod)
    );

    // Digits driven since the last acceptance; digit 7 is the signed top digit.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tbDig <= -1;
        end else if (in_valid && in_ready) begin
            tbDig <= 0;
        end else if (tbDig >= 0) begin
            tbDig <= tbDig + 1;
        end
    end

    always_comb begin
        digVal = {30'd0, lay_b_high, lay_b_low};
        if (tbDig == 7 && lay_b_high) begin
            digVal = digVal - 4;
        end
        layA    = int'($signed(lay_a));
        lay_sum = 18'(layA * digVal);
    end

    function automatic logic [31:0] refProd(input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 32'(sa * sb);
    endfunction

    // Runs one operation with out_ready=1; reports latency in edges and mid-run samples at k=2.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 output int lat, output logic [31:0] prod,
                                 output logic midRdy, output logic [15:0] midA,
                                 output logic [1:0] midDig, output logic midCin,
                                 output bit to);
        int w;
        int n;
        to = 1'b0; lat = -1; prod = '0;
        midRdy = 1'bx; midA = 'x; midDig = 'x; midCin = 1'bx;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            to = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 30) begin
            if (n == 3) begin
                midRdy = in_ready; midA = lay_a;
                midDig = {lay_b_high, lay_b_low}; midCin = lay_cin;
            end
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            to = 1'b1;
        end else begin
            lat  = n - 1;
            prod = out_prod;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); else nPass++;
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); else nPass++;
        nChecks++; if (out_prod !== 32'h0) $display("[TB] FAIL reset_out_prod: got %h want 0", out_prod); else nPass++;
        nChecks++; if (lay_a !== 16'h0) $display("[TB] FAIL reset_lay_a: got %h want 0", lay_a); else nPass++;
        nChecks++; if ({lay_b_high, lay_b_low, lay_cin} !== 3'b000)
            $display("[TB] FAIL reset_lay_bits: got %b want 000", {lay_b_high, lay_b_low, lay_cin}); else nPass++;
    endtask

    task automatic test_basic();
        logic [15:0] aTab [3];
        logic [15:0] bTab [3];
        int lat; logic [31:0] prod; logic mr, mc; logic [15:0] ma; logic [1:0] md; bit to;
        aTab[0] = 16'd3;      bTab[0] = 16'd5;
        aTab[1] = 16'hFFFE;   bTab[1] = 16'd3;
        aTab[2] = 16'h8000;   bTab[2] = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(aTab[i], bTab[i], lat, prod, mr, ma, md, mc, to);
            nChecks++; if (to || prod !== refProd(aTab[i], bTab[i]))
                $display("[TB] FAIL basic_prod[%0d]: got %h want %h (timeout=%0d)", i, prod, refProd(aTab[i], bTab[i]), to); else nPass++;
            nChecks++; if (lat != LAT) $display("[TB] FAIL basic_latency[%0d]: got %0d want %0d", i, lat, LAT); else nPass++;
            nChecks++; if (mr !== 1'b0) $display("[TB] FAIL basic_run_in_ready[%0d]: got %b want 0", i, mr); else nPass++;
            nChecks++; if (ma !== aTab[i]) $display("[TB] FAIL basic_lay_a[%0d]: got %h want %h", i, ma, aTab[i]); else nPass++;
            nChecks++; if (md !== bTab[i][5:4]) $display("[TB] FAIL basic_digit2[%0d]: got %b want %b", i, md, bTab[i][5:4]); else nPass++;
            nChecks++; if (mc !== 1'b0) $display("[TB] FAIL basic_lay_cin[%0d]: got %b want 0", i, mc); else nPass++;
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        int lat; logic [31:0] prod; logic mr, mc; logic [15:0] ma; logic [1:0] md; bit to;
        for (int i = 0; i < 14; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            if (i == 0) begin a = 16'h7FFF; b = 16'h8000; end
            if (i == 1) begin a = 16'h8000; b = 16'h7FFF; end
            if (i == 2) begin a = 16'hFFFF; b = 16'h7FFF; end
            applyStimulus(a, b, lat, prod, mr, ma, md, mc, to);
            nChecks++; if (to || prod !== refProd(a, b))
                $display("[TB] FAIL random_prod[%0d] a=%h b=%h: got %h want %h", i, a, b, prod, refProd(a, b)); else nPass++;
            nChecks++; if (lat != LAT) $display("[TB] FAIL random_latency[%0d]: got %0d want %0d", i, lat, LAT); else nPass++;
        end
    endtask

    task automatic test_hold();
        logic [31:0] first;
        int w;
        @(negedge clk);
        in_a = 16'd1234; in_b = 16'hFDC9; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 30) begin @(negedge clk); w++; end
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 30) begin @(negedge clk); w++; end
        first = out_prod;
        nChecks++; if (!out_valid || first !== refProd(16'd1234, 16'hFDC9))
            $display("[TB] FAIL hold_prod: got %h want %h", first, refProd(16'd1234, 16'hFDC9)); else nPass++;
        in_a = 16'h0123; in_b = 16'hFF00; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nChecks++; if (out_prod !== first) $display("[TB] FAIL hold_stable[%0d]: got %h want %h", c, out_prod, first); else nPass++;
            nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL hold_valid[%0d]: got %b want 1", c, out_valid); else nPass++;
            nChecks++; if (in_ready !== 1'b0) $display("[TB] FAIL hold_in_ready[%0d]: got %b want 0", c, in_ready); else nPass++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL hold_release_in_ready: got %b want 1", in_ready); else nPass++;
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL hold_release_valid: got %b want 0", out_valid); else nPass++;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 30) begin @(negedge clk); w++; end
        nChecks++; if (!out_valid || out_prod !== refProd(16'h0123, 16'hFF00))
            $display("[TB] FAIL hold_pending_prod: got %h want %h", out_prod, refProd(16'h0123, 16'hFF00)); else nPass++;
    endtask

    task automatic test_abort();
        int w;
        bit sawValid;
        int lat; logic [31:0] prod; logic mr, mc; logic [15:0] ma; logic [1:0] md; bit to;
        @(negedge clk);
        in_a = 16'h4D2B; in_b = 16'hB1E7; in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 30) begin @(negedge clk); w++; end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL abort_out_valid: got %b want 0", out_valid); else nPass++;
        nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL abort_in_ready: got %b want 1", in_ready); else nPass++;
        nChecks++; if ({lay_a, lay_b_high, lay_b_low, lay_cin} !== 19'h0)
            $display("[TB] FAIL abort_lay: got %h want 0", {lay_a, lay_b_high, lay_b_low, lay_cin}); else nPass++;
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        nChecks++; if (sawValid) $display("[TB] FAIL abort_no_output: got valid=1 want 0"); else nPass++;
        applyStimulus(16'd7, 16'd7, lat, prod, mr, ma, md, mc, to);
        nChecks++; if (to || prod !== 32'd49) $display("[TB] FAIL abort_next_prod: got %h want %h", prod, 32'd49); else nPass++;
    endtask

    task automatic test_back_to_back();
        int acceptAt [$];
        logic [31:0] results [$];
        bit pendingSwitch;
        pendingSwitch = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_a = 16'd1; in_b = 16'd1; in_valid = 1'b1;
        for (int c = 0; c < 60 && results.size() < 2; c++) begin
            if (c > 0) @(negedge clk);
            if (pendingSwitch) begin
                pendingSwitch = 1'b0;
                if (acceptAt.size() == 1) begin
                    in_a = 16'hFFFF; in_b = 16'hFFFF;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (in_valid && in_ready) begin
                acceptAt.push_back(c);
                pendingSwitch = 1'b1;
            end
            if (out_valid) results.push_back(out_prod);
        end
        in_valid = 1'b0;
        nChecks++; if (results.size() != 2 || acceptAt.size() != 2)
            $display("[TB] FAIL b2b_count: got %0d results %0d accepts want 2 2", results.size(), acceptAt.size()); else nPass++;
        if (results.size() == 2 && acceptAt.size() == 2) begin
            nChecks++; if (results[0] !== 32'd1) $display("[TB] FAIL b2b_prod0: got %h want 1", results[0]); else nPass++;
            nChecks++; if (results[1] !== 32'd1) $display("[TB] FAIL b2b_prod1: got %h want 1", results[1]); else nPass++;
            nChecks++; if (acceptAt[1] - acceptAt[0] != SPACING)
                $display("[TB] FAIL b2b_spacing: got %0d want %0d", acceptAt[1] - acceptAt[0], SPACING); else nPass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL in_reset_outputs: got ready=%b valid=%b want 1 0", in_ready, out_valid); else nPass++;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/app_mult_serial_acc16.md
# app_mult_serial_acc16

Sequential controller/accumulator for the signed 16x16 approximate multiplier. It accepts an operand pair over a valid/ready handshake, then walks B in 2-bit digits. Each cycle it drives the external 16x2 partial-product layer and shift-accumulates the layer's 18-bit sum into a 32-bit product, which it presents on an output valid/ready handshake. It sits directly downstream of the partial-product layer and drives all of that layer's inputs.

## Interface
- `WIDTH`, 16: operand width; must be even.
- `DIGITS`, WIDTH/2: number of 2-bit digits of B, one layer pass per digit.
- `LSUM_W`, WIDTH+2: width of the layer sum.
- `PROD_W`, 2*WIDTH: product width.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operands `in_a`/`in_b` are valid.
- `in_ready` out 1: block accepts operands; reset value 1.
- `in_a` in WIDTH: signed multiplicand.
- `in_b` in WIDTH: signed multiplier.
- `lay_a` out WIDTH: layer multiplicand (registered A); reset value 0.
- `lay_b_low` out 1: layer digit bit 0, equal to B[2k]; reset value 0.
- `lay_b_high` out 1: layer digit bit 1, equal to B[2k+1]; reset value 0.
- `lay_cin` out 1: layer carry-in, tied 0; reset value 0.
- `lay_sum` in LSUM_W: signed layer result, combinational from the `lay_*` outputs.
- `out_valid` out 1: `out_prod` is valid; reset value 0.
- `out_ready` in 1: downstream accepts the product.
- `out_prod` out PROD_W: signed product; reset value 0.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE with `acc`=0, `k`=0 and all outputs at their reset values.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: register A and B, clear `acc`, set `k`=0, go to RUN.
- RUN:
  - `in_ready`=0.
  - `lay_a`=A and `{lay_b_high,lay_b_low}`=B[2k+1:2k].
  - Each cycle: `acc` <= `acc` + (sext(`lay_sum`) << 2k). The shift and add are done at PROD_W+3 bits.
  - `k` increments each cycle. After the capture for k=DIGITS-1, go to DONE.
- DONE:
  - `out_valid`=1 and `out_prod`=`acc`[PROD_W-1:0]. Upper guard bits are discarded with no saturation.
  - `out_prod` and `out_valid` hold stable until `out_ready`=1. On `out_ready`=1, go to IDLE.
- Signedness of the top digit is the layer's responsibility; the accumulator only sign-extends `lay_sum`.
- No new operands are accepted in RUN or DONE.
- `in_valid` while `in_ready`=0 is ignored; the upstream must hold it.
- A `rst` pulse in any state aborts the current operation. The block immediately returns to IDLE with reset values, and no partial product is ever emitted.

## Timing
- Operands are accepted at edge T.
- Digit k is driven in cycle T+1+k and captured at edge T+1+k.
- `out_valid` rises after edge T+DIGITS. For 16-bit operands that is 8 cycles after acceptance, and the output is visible in cycle T+9.
- Back-to-back operation:
  - `out_ready` is sampled in DONE. If it is 1, the block returns to IDLE at that edge.
  - `in_ready` is 1 in the following cycle.
  - Minimum spacing between operand acceptances is DIGITS+2 cycles.
- `lay_*` outputs change only at clock edges, so the layer path is a single-cycle combinational path, register to register.

## Configuration
- `APP_MULT_LAYER_REG_EN`:
  - Defined: `lay_sum` is registered before accumulation. Digit k is captured one edge later, the pipeline drains one extra cycle before DONE, and `out_valid` rises after edge T+DIGITS+1 (9 cycles for 16-bit operands). The layer path is then broken from the adder. Products are identical to the undefined case.
  - Undefined: direct accumulation as described in Operation and Timing.

## Structure
- Shared package holds:
  - state enum `{IDLE, RUN, DONE}`;
  - `WIDTH`, `DIGITS`, `LSUM_W`, `PROD_W` defaults;
  - the accumulator guard-bit constant (3).
- One sub-module, `serial_acc_ctrl`: the FSM, digit counter `k` and handshake logic. It outputs the `k` index and the `acc_clr`/`acc_en`/`done` strobes.
- The top level holds the operand registers, digit mux, optional `lay_sum` register and accumulator.

## Test plan
- Bench model for `lay_sum`: sext(`lay_a`) × unsigned digit for k<7 and × signed digit for k=7. This model makes the product exact.
- A=3, B=5 -> `out_prod`=15 (0x0000000F), `out_valid` 8 cycles after acceptance (9 with `APP_MULT_LAYER_REG_EN`).
- A=-2, B=3 -> 0xFFFFFFFA; A=-32768, B=-32768 -> 0x40000000.
- In DONE with `out_ready`=0 for 5 cycles: `out_prod` stable, `in_ready`=0. A pending `in_valid` is accepted only one cycle after `out_ready`=1.
- `rst` asserted during RUN at k=4: `out_valid`=0, `in_ready`=1 and `lay_*`=0 immediately. The next operation (7×7) yields 49.
- Back-to-back A=1,B=1 then A=-1,B=-1 with `out_ready` tied 1: results 1 then 1, acceptances 10 cycles apart.
